seq_detect_ctrl: RTL and testbench

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

---
 rtl/seq_detect_ctrl_pkg.sv | 34 +++
 rtl/seq_match_core.sv | 63 ++++++
 rtl/seq_detect_ctrl.sv | 171 +++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_ctrl_pkg.sv
// seq_detect_ctrl_pkg
// Shared types and constants for the serial sequence detector.
//   state_t            : controller states IDLE / RUN / DONE
//   PAT_W              : width of the pattern and history registers
//   LEN_W              : width of the pattern-length field
//   LEN_MIN / LEN_MAX  : legal pattern-length range
//   DEF_*              : configuration loaded into the shadow registers at reset
//   len_legal()        : range check for a pattern length
// Optional feature macro used by the design: SEQ_DETECT_CTRL_TIMEOUT_EN
package seq_detect_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;

  localparam logic [LEN_W-1:0] LEN_MIN = 4'd2;
  localparam logic [LEN_W-1:0] LEN_MAX = 4'd8;

  localparam logic [PAT_W-1:0] DEF_PATTERN = 8'b0000_0101;
  localparam logic [LEN_W-1:0] DEF_LEN     = 4'd3;
  localparam logic             DEF_OVERLAP = 1'b1;
  localparam int               DEF_TARGET  = 1;
  localparam int               DEF_TIMEOUT = 0;

  function automatic logic len_legal(input logic [LEN_W-1:0] len);
    return (len >= LEN_MIN) && (len <= LEN_MAX);
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// seq_match_core
// History shift register, saturating bit counter and pattern comparator.
// Ports:
//   clk, reset_n  : clock and synchronous active-low reset
//   clear         : synchronous clear of history and bit count
//   enable        : controller is in RUN (data may be consumed)
//   overlap       : 1 = keep progress after a hit, 0 = restart counting
//   d_valid, d_in : serial input bit and its qualifier
//   pattern, len  : pattern to detect (bit len-1 arrives first) and length
//   hit           : combinational, the current bit completes the pattern
module seq_match_core
  import seq_detect_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             overlap,
  input  logic             d_valid,
  input  logic             d_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             hit
);

  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] bit_cnt;
  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] mask;
  logic             unused_hist_msb;

  assign unused_hist_msb = hist[PAT_W-1];

  // The window is the history as it would look with d_in shifted in; only
  // its low len bits are compared, so the mask selects them.
  always_comb begin
    window = {hist[PAT_W-2:0], d_in};
    mask   = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    hit = enable && d_valid &&
          (bit_cnt >= (len - LEN_W'(1))) &&
          ((window & mask) == (pattern & mask));
  end

  // In non-overlap mode a hit zeroes the bit count so the next hit needs a
  // full len fresh bits; the history keeps shifting either way.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      hist    <= '0;
      bit_cnt <= '0;
    end else if (enable && d_valid) begin
      hist <= window;
      if (hit && !overlap) begin
        bit_cnt <= '0;
      end else if (bit_cnt < len) begin
        bit_cnt <= bit_cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
// Serial sequence detector with a three-state controller (IDLE/RUN/DONE).
// Counts pattern matches on a qualified bit stream until a target count is
// reached, optionally bounded by a RUN-cycle budget.
// Ports:
//   clk, reset_n           : clock, synchronous active-low reset
//   cfg_we                 : write cfg_* into shadow registers (IDLE/DONE only)
//   cfg_pattern, cfg_len   : pattern (bit len-1 first) and length 2..8
//   cfg_overlap            : overlapping (1) or non-overlapping (0) detection
//   cfg_target             : matches needed to finish, nonzero
//   cfg_timeout            : RUN-cycle budget, 0 = unlimited
//   start, abort           : arm detection / return to IDLE
//   d_valid, d_in          : serial data
//   match                  : Mealy pulse on the completing bit
//   match_cnt              : registered match count
//   busy, done             : state is RUN / DONE
//   timeout                : sticky, DONE was reached by budget expiry
//   cfg_err                : one-cycle pulse on illegal start or write in RUN
// Optional feature: define SEQ_DETECT_CTRL_TIMEOUT_EN to build the RUN-cycle
// timer; without it cfg_timeout is ignored and timeout is tied low.
module seq_detect_ctrl
  import seq_detect_ctrl_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [TMO_W-1:0] cfg_timeout,
  input  logic             start,
  input  logic             abort,
  input  logic             d_valid,
  input  logic             d_in,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             cfg_err
);

  state_t           state;
  logic [PAT_W-1:0] sh_pattern;
  logic [LEN_W-1:0] sh_len;
  logic             sh_overlap;
  logic [CNT_W-1:0] sh_target;
  logic             cfg_legal;
  logic             run_en;
  logic             core_clear;
  logic [CNT_W-1:0] cnt_next;
  logic             final_match;

`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  logic [TMO_W-1:0] sh_timeout;
  logic [TMO_W-1:0] timer;
  logic             expire;
`else
  logic             unused_cfg_timeout;

  assign unused_cfg_timeout = ^cfg_timeout;
  assign timeout            = 1'b0;
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // The match pulse is gated by reset_n so it stays low during a reset edge
  // even if the state register still holds RUN.
  always_comb begin
    cfg_legal   = len_legal(sh_len) && (sh_target != '0);
    run_en      = reset_n && (state == RUN);
    core_clear  = abort || (start && cfg_legal && (state != RUN));
    cnt_next    = match_cnt + CNT_W'(1);
    final_match = match && (cnt_next == sh_target);
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    expire      = (sh_timeout != '0) && ((timer + TMO_W'(1)) == sh_timeout);
`endif
  end

  seq_match_core u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (core_clear),
    .enable  (run_en),
    .overlap (sh_overlap),
    .d_valid (d_valid),
    .d_in    (d_in),
    .pattern (sh_pattern),
    .len     (sh_len),
    .hit     (match)
  );

  // Controller, config shadow and counters. abort outranks everything else;
  // a final match outranks budget expiry so the run ends as a success.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      match_cnt  <= '0;
      cfg_err    <= 1'b0;
      sh_pattern <= DEF_PATTERN;
      sh_len     <= DEF_LEN;
      sh_overlap <= DEF_OVERLAP;
      sh_target  <= CNT_W'(DEF_TARGET);
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
      sh_timeout <= TMO_W'(DEF_TIMEOUT);
      timer      <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      cfg_err <= 1'b0;
      if (cfg_we) begin
        if (state == RUN) begin
          cfg_err <= 1'b1;
        end else begin
          sh_pattern <= cfg_pattern;
          sh_len     <= cfg_len;
          sh_overlap <= cfg_overlap;
          sh_target  <= cfg_target;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
          sh_timeout <= cfg_timeout;
`endif
        end
      end
      if (abort) begin
        state <= IDLE;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
        timer <= '0;
`endif
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              if (cfg_legal) begin
                state     <= RUN;
                match_cnt <= '0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
                timer     <= '0;
                timeout   <= 1'b0;
`endif
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          RUN: begin
            if (match) begin
              match_cnt <= cnt_next;
            end
            if (final_match) begin
              state <= DONE;
            end
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
            else if (expire) begin
              state   <= DONE;
              timeout <= 1'b1;
            end
            timer <= timer + TMO_W'(1);
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl
// Self-checking bench for seq_detect_ctrl: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference model.
// Timer checks adapt to whether SEQ_DETECT_CTRL_TIMEOUT_EN is defined.
module tb_seq_detect_ctrl;

  localparam int CNT_W = 8;
  localparam int TMO_W = 16;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic             clk;
  logic             reset_n;
  logic             cfg_we;
  logic [7:0]       cfg_pattern;
  logic [3:0]       cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;
  logic [TMO_W-1:0] cfg_timeout;
  logic             start;
  logic             abort;
  logic             d_valid;
  logic             d_in;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;
  logic             done;
  logic             timeout;
  logic             cfg_err;

  seq_detect_ctrl #(.CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .cfg_timeout (cfg_timeout),
    .start       (start),
    .abort       (abort),
    .d_valid     (d_valid),
    .d_in        (d_in),
    .match       (match),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .cfg_err     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: state 0=idle 1=run 2=done, bits received since arming
  // (or since the last match in non-overlap mode) kept in a queue.
  int         m_state;
  int         m_cnt;
  bit         m_tmo;
  bit         m_err;
  int         m_cycles;
  bit         m_bits[$];
  logic [7:0] c_pat;
  int         c_len;
  bit         c_ovl;
  int         c_target;
  int         c_tmo;

  int checks;
  int failures;
  int match_seen;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_match(input bit dv_i, input bit din_i);
    bit tmp[$];
    int sz;
    if (m_state != 1 || !dv_i) return 1'b0;
    tmp = m_bits;
    tmp.push_back(din_i);
    sz = tmp.size();
    if (sz < c_len) return 1'b0;
    for (int i = 0; i < c_len; i++) begin
      if (tmp[sz-1-i] != c_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic modelStep(input bit rst_i, input bit we_i, input bit start_i,
                           input bit abort_i, input bit dv_i, input bit din_i,
                           input bit hit);
    int ps;
    bit legal;
    bit err_next;
    if (!rst_i) begin
      m_state = 0; m_cnt = 0; m_tmo = 0; m_err = 0; m_cycles = 0;
      m_bits.delete();
      c_pat = 8'd5; c_len = 3; c_ovl = 1; c_target = 1; c_tmo = 0;
      return;
    end
    ps       = m_state;
    legal    = (c_len >= 2) && (c_len <= 8) && (c_target != 0);
    err_next = 1'b0;
    if (abort_i) begin
      m_state = 0;
      m_cycles = 0;
      m_bits.delete();
    end else if (ps != 1) begin
      if (start_i) begin
        if (legal) begin
          m_state = 1; m_cnt = 0; m_cycles = 0; m_tmo = 0;
          m_bits.delete();
        end else begin
          err_next = 1'b1;
        end
      end
    end else begin
      m_cycles++;
      if (dv_i) begin
        m_bits.push_back(din_i);
        while (m_bits.size() > 8) void'(m_bits.pop_front());
      end
      if (hit) begin
        m_cnt++;
        if (!c_ovl) m_bits.delete();
        if (m_cnt == c_target) m_state = 2;
      end
      if (m_state == 1 && TMO_EN && c_tmo != 0 && m_cycles == c_tmo) begin
        m_state = 2;
        m_tmo   = 1'b1;
      end
    end
    if (we_i) begin
      if (ps == 1) begin
        err_next = 1'b1;
      end else begin
        c_pat = cfg_pattern; c_len = int'(cfg_len); c_ovl = cfg_overlap;
        c_target = int'(cfg_target); c_tmo = int'(cfg_timeout);
      end
    end
    m_err = err_next;
  endtask

  // One clock cycle: drive inputs, check the Mealy output mid-cycle, advance
  // the model, then check registered outputs just after the edge.
  task automatic applyStimulus(input bit rst_i, input bit we_i, input bit start_i,
                               input bit abort_i, input bit dv_i, input bit din_i);
    bit exp_m;
    reset_n = rst_i; cfg_we = we_i; start = start_i;
    abort = abort_i; d_valid = dv_i; d_in = din_i;
    #1;
    exp_m = rst_i && model_match(dv_i, din_i);
    checkOutput("match", match, exp_m);
    if (match === 1'b1) match_seen++;
    modelStep(rst_i, we_i, start_i, abort_i, dv_i, din_i, exp_m);
    @(posedge clk);
    #1;
    checkOutput("match_cnt", 32'(match_cnt), 32'(m_cnt[CNT_W-1:0]));
    checkOutput("busy", busy, m_state == 1);
    checkOutput("done", done, m_state == 2);
    checkOutput("timeout", timeout, m_tmo);
    checkOutput("cfg_err", cfg_err, m_err);
  endtask

  task automatic cfgWrite(input logic [7:0] pat, input logic [3:0] len, input bit ovl,
                          input int target, input int tmo);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    cfg_target = CNT_W'(target); cfg_timeout = TMO_W'(tmo);
    applyStimulus(1, 1, 0, 0, 0, 0);
  endtask

  task automatic sendStream(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(1, 0, 0, 0, 1, bits[i]);
  endtask

  initial begin
    checks = 0; failures = 0; match_seen = 0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_target = '0; cfg_timeout = '0;

    $display("[TB] reset");
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] overlap, target 3");
    cfgWrite(8'b101, 4'd3, 1, 3, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    match_seen = 0;
    sendStream(16'b1010101, 7);
    checkOutput("s1_pulses", match_seen, 3);
    checkOutput("s1_done", done, 1);
    checkOutput("s1_cnt", 32'(match_cnt), 3);

    $display("[TB] non-overlap, target 2");
    cfgWrite(8'b101, 4'd3, 0, 2, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    match_seen = 0;
    sendStream(16'b1010101, 7);
    checkOutput("s2_pulses", match_seen, 2);
    checkOutput("s2_done", done, 1);
    checkOutput("s2_cnt", 32'(match_cnt), 2);

    $display("[TB] gaps in d_valid");
    cfgWrite(8'b1011, 4'd4, 1, 1, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    match_seen = 0;
    begin
      logic [3:0] p;
      p = 4'b1011;
      for (int i = 3; i >= 0; i--) begin
        applyStimulus(1, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
        applyStimulus(1, 0, 0, 0, 1, p[i]);
      end
    end
    checkOutput("s3_pulses", match_seen, 1);
    checkOutput("s3_done", done, 1);

    $display("[TB] illegal config and write during RUN");
    cfgWrite(8'b101, 4'd1, 1, 1, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    checkOutput("s4_len_err", cfg_err, 1);
    checkOutput("s4_idle", busy, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    cfgWrite(8'b101, 4'd3, 1, 2, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    match_seen = 0;
    cfg_pattern = 8'b111;
    applyStimulus(1, 1, 0, 0, 1, 1);
    checkOutput("s4_run_err", cfg_err, 1);
    sendStream(16'b01, 2);
    checkOutput("s4_old_cfg", match_seen, 1);
    checkOutput("s4_busy", busy, 1);

    $display("[TB] abort with start");
    applyStimulus(1, 0, 1, 1, 1, 1);
    checkOutput("s7_busy", busy, 0);
    checkOutput("s7_done", done, 0);
    checkOutput("s7_cnt", 32'(match_cnt), 1);

    $display("[TB] timeout budget");
    cfgWrite(8'b101, 4'd3, 1, 1, 5);
    applyStimulus(1, 0, 1, 0, 0, 0);
    sendStream(16'b00000, 5);
    checkOutput("s6_done", done, 32'(TMO_EN));
    checkOutput("s6_timeout", timeout, 32'(TMO_EN));
    applyStimulus(1, 0, 0, 1, 0, 0);
    cfgWrite(8'b101, 4'd3, 1, 1, 3);
    applyStimulus(1, 0, 1, 0, 0, 0);
    sendStream(16'b101, 3);
    checkOutput("s6_tie_done", done, 1);
    checkOutput("s6_tie_timeout", timeout, 0);

    $display("[TB] reset mid-run");
    cfgWrite(8'b101, 4'd3, 1, 3, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    sendStream(16'b10, 2);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("s8_busy", busy, 0);
    checkOutput("s8_cnt", 32'(match_cnt), 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    sendStream(16'b101, 3);
    checkOutput("s8_default_done", done, 1);
    checkOutput("s8_default_cnt", 32'(match_cnt), 1);

    $display("[TB] random phase");
    for (int n = 0; n < 600; n++) begin
      bit rst_r, we_r, st_r, ab_r, dv_r, din_r;
      rst_r = ($urandom_range(0, 99) != 0);
      we_r  = ($urandom_range(0, 19) == 0);
      st_r  = ($urandom_range(0, 7) == 0);
      ab_r  = ($urandom_range(0, 39) == 0);
      dv_r  = ($urandom_range(0, 3) != 0);
      din_r = 1'($urandom_range(0, 1));
      cfg_pattern = 8'($urandom);
      cfg_len     = 4'($urandom_range(1, 9));
      cfg_overlap = 1'($urandom_range(0, 1));
      cfg_target  = CNT_W'($urandom_range(0, 4));
      cfg_timeout = TMO_W'($urandom_range(0, 12));
      applyStimulus(rst_r, we_r, st_r, ab_r, dv_r, din_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
